// File: rtl/handshake_skid_pkg.sv
// Shared types and encodings for the two-entry valid/ready skid buffer.
package handshake_skid_pkg;

    typedef enum logic [1:0] {EMPTY, BUSY, FULL} skid_state_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_BUSY  = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    function automatic logic [1:0] occupancy_of(input skid_state_t state);
        logic [1:0] occ;
        case (state)
            EMPTY:   occ = OCC_EMPTY;
            BUSY:    occ = OCC_BUSY;
            FULL:    occ = OCC_FULL;
            default: occ = OCC_EMPTY;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/register_slice.sv
// Clock-enabled data register with synchronous, active-high reset to a fixed value.
module register_slice #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RESET_VALUE;
        end else if (clk_en) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/handshake_skid_buffer.sv
// Two-entry valid/ready stage: cuts the ready path while sustaining one transfer per cycle.
module handshake_skid_buffer
    import handshake_skid_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic [1:0]            occupancy
);

    skid_state_t           state_q, state_d;
    logic                  in_fire, out_fire;
    logic                  main_en, skid_en;
    logic [DATA_WIDTH-1:0] main_d, main_q, skid_q;

    // Ready depends only on state and reset, never on data_out_ready.
    assign data_in_ready  = (state_q != FULL) & ~rst;
    assign data_out_valid = (state_q != EMPTY);
    assign data_out       = main_q;
    assign occupancy      = occupancy_of(state_q);

    assign in_fire  = data_in_valid & data_in_ready;
    assign out_fire = data_out_valid & data_out_ready;

    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        skid_en = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_en = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && data_out_ready) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    skid_en = 1'b1;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (data_out_ready) begin
                    main_en = 1'b1;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Main refills from skid when draining FULL, otherwise straight from the producer.
    assign main_d = (state_q == FULL) ? skid_q : data_in;

    register_slice #(
        .DATA_WIDTH  (DATA_WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_main (
        .clk    (clk),
        .rst    (rst),
        .clk_en (main_en),
        .d      (main_d),
        .q      (main_q)
    );

    register_slice #(
        .DATA_WIDTH  (DATA_WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .clk_en (skid_en),
        .d      (data_in),
        .q      (skid_q)
    );

    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        (data_out_valid && !data_out_ready) |=> (data_out_valid && $stable(data_out)));

endmodule
